store_buffer_dmem: RTL and testbench
====================================

Name: store_buffer_dmem

Overview:
- Write-buffered data-memory port between the processor's Memory stage and the external data RAM.
- Accepts one store per cycle from the Memory stage (memw_m, m_address, m_data) into a FIFO.
- Drains buffered stores to the RAM over a req/ack handshake.
- Returns load data combinationally into the processor's input_data path, so the Memory/Writeback register captures it on the same edge.

Parameters:
- DEPTH, 4: store-buffer entries; power of two, minimum 2.
- ADDR_W, 10: RAM word-address width; word address is addr[ADDR_W+1:2].
- DATA_W, 32: data word width.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- wr_en  in  1  store request from Memory stage (memw_m).
- rd_en  in  1  load request from Memory stage.
- addr  in  32  byte address (m_address); bits [1:0] ignored.
- wdata  in  DATA_W  store data (m_data).
- rdata  out  DATA_W  load data to the processor (input_data).
- full  out  1  buffer holds DEPTH entries.
- empty  out  1  buffer holds 0 entries.
- overflow  out  1  sticky: a store was dropped.
- ram_req  out  1  drain write request.
- ram_addr  out  ADDR_W  drain write word address.
- ram_wdata  out  DATA_W  drain write data.
- ram_ack  in  1  RAM accepted the current write.
- ram_raddr  out  ADDR_W  asynchronous read port address; equals addr[ADDR_W+1:2].
- ram_rdata  in  DATA_W  asynchronous read port data.

Behaviour:
- Reset (rst=0, asynchronous):
  - pointers, count, overflow, ram_req, ram_addr and ram_wdata go to 0;
  - empty=1, full=0;
  - FSM enters IDLE.
  - Reset mid-handshake drops ram_req immediately; buffered entries are discarded.
- FIFO:
  - head/tail pointers of width log2(DEPTH) wrap modulo DEPTH; count has width log2(DEPTH)+1.
  - full = (count==DEPTH); empty = (count==0), both decoded from registered count.
  - Push: a cycle with wr_en=1 and full=0 writes {addr word, wdata} at tail; tail advances.
  - Drop: a cycle with wr_en=1 and full=1 drops the store, even if a pop occurs in the same cycle, and sets overflow. overflow clears only on reset.
  - Push and pop in the same cycle leave count unchanged.
- Drain FSM (IDLE, REQ):
  - IDLE, empty=0: register the head entry onto ram_addr/ram_wdata, set ram_req=1, go to REQ. First request appears 1 cycle after the first push.
  - REQ: hold ram_req, ram_addr and ram_wdata stable until ram_ack=1.
  - On ack: pop the head, clear ram_req, return to IDLE.
  - Throughput is at most 1 drain per 2 cycles.
  - ram_ack while in IDLE is ignored.
- Load path, combinational:
  - rd_en=0: rdata=0.
  - rd_en=1: rdata = the forwarded value (see Optional Feature) if one exists, otherwise ram_rdata.
  - A store and a load to the same address in the same cycle: the load does not see that store; it sees older buffered or RAM data.
  - The entry currently in REQ stays in the buffer until ack, so it remains forwardable.

Optional Feature:
- Macro: STORE_FORWARD_EN.
- Defined: on rd_en=1, all valid entries are compared to addr[ADDR_W+1:2]. The youngest match, nearest the tail, supplies rdata.
- Undefined: no comparators; rdata = ram_rdata when rd_en=1. Software must not load an address with a pending store; empty is exported for polling.

Decomposition:
- Package dmem_pkg:
  - drain_state_t enum {IDLE, REQ};
  - typedef sb_entry_t {logic [ADDR_W-1:0] addr; logic [DATA_W-1:0] data;} with default widths;
  - localparam DMEM_ADDR_W=10.
- One sub-module, store_fifo:
  - circular buffer, pointers, count, full/empty, overflow;
  - exposes entry array and a per-entry valid vector for the forwarding search.
- Top level holds the drain FSM and the load mux.

Test Plan:
- Reset: hold rst=0 with wr_en=1 -> full=0, empty=1, ram_req=0, overflow=0, rdata=0.
- Single store: addr=0x10, wdata=0xCAFE0001 -> next cycle ram_req=1, ram_addr=4, ram_wdata=0xCAFE0001; req held 3 cycles until ram_ack pulse; then empty=1.
- Fill: 4 stores with ram_ack=0 -> full=1; 5th store is dropped and overflow=1 sticky; after acks, exactly 4 RAM writes appear, in order.
- Forwarding (STORE_FORWARD_EN): store 0x11 then 0x22 to addr 0x20, ram_rdata=0xDEAD, rd_en=1 addr 0x20 -> rdata=0x22. Without the macro -> 0xDEAD.
- Same-cycle push/pop: full buffer, ram_ack=1 with wr_en=1 -> store dropped, overflow=1, count 3. Count-3 buffer with the same event -> count stays 3.
- Mid-handshake reset: ram_req=1, assert rst=0 -> ram_req=0 immediately; after release, no further requests.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared types and widths for the store-buffered data-memory port.
// Optional store-to-load forwarding is enabled with the STORE_FORWARD_EN macro.
package dmem_pkg;

    localparam int unsigned DMEM_ADDR_W = 10;
    localparam int unsigned DMEM_DATA_W = 32;

    typedef enum logic {
        IDLE = 1'b0,
        REQ  = 1'b1
    } drain_state_t;

    // One buffered store: RAM word address plus data
    typedef struct packed {
        logic [DMEM_ADDR_W-1:0] addr;
        logic [DMEM_DATA_W-1:0] data;
    } sb_entry_t;

endpackage

// File: rtl/store_buffer_dmem_if.sv
// Memory-stage and data-RAM signals of the store buffer, grouped in one bundle.
// slave = the store buffer itself; master = processor plus RAM side.
interface store_buffer_dmem_if
    import dmem_pkg::*;
#(
    parameter int unsigned ADDR_W = DMEM_ADDR_W,
    parameter int unsigned DATA_W = DMEM_DATA_W
);

    logic              wr_en;
    logic              rd_en;
    logic [31:0]       addr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;
    logic              full;
    logic              empty;
    logic              overflow;

    logic              ram_req;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic              ram_ack;
    logic [ADDR_W-1:0] ram_raddr;
    logic [DATA_W-1:0] ram_rdata;

    modport slave (
        input  wr_en, rd_en, addr, wdata, ram_ack, ram_rdata,
        output rdata, full, empty, overflow, ram_req, ram_addr, ram_wdata, ram_raddr
    );

    modport master (
        output wr_en, rd_en, addr, wdata, ram_ack, ram_rdata,
        input  rdata, full, empty, overflow, ram_req, ram_addr, ram_wdata, ram_raddr
    );

endinterface

// File: rtl/store_fifo.sv
// Circular store buffer: head/tail pointers, occupancy count, sticky overflow,
// and a per-entry valid vector so the top level can search pending stores.
module store_fifo
    import dmem_pkg::*;
#(
    parameter  int unsigned DEPTH = 4,
    localparam int unsigned PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push_req,
    input  sb_entry_t        i_push_entry,
    input  logic             i_pop,
    output sb_entry_t        o_head_entry,
    output logic [PTR_W-1:0] o_head,
    output sb_entry_t        o_entries [DEPTH],
    output logic [DEPTH-1:0] o_valid,
    output logic             o_full,
    output logic             o_empty,
    output logic             o_overflow
);

    localparam int unsigned CNT_W = PTR_W + 1;

    sb_entry_t        r_mem [DEPTH];
    logic [PTR_W-1:0] r_head;
    logic [PTR_W-1:0] r_tail;
    logic [CNT_W-1:0] r_count;
    logic             r_overflow;
    logic             w_push;
    logic             w_pop;

    assign o_full  = (r_count == CNT_W'(DEPTH));
    assign o_empty = (r_count == '0);

    // A store arriving while full is dropped even if a pop frees a slot this cycle
    assign w_push = i_push_req && !o_full;
    assign w_pop  = i_pop && !o_empty;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_head     <= '0;
            r_tail     <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_tail <= r_tail + PTR_W'(1);
            end
            if (w_pop) begin
                r_head <= r_head + PTR_W'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CNT_W'(1);
            end else if (!w_push && w_pop) begin
                r_count <= r_count - CNT_W'(1);
            end
            if (i_push_req && o_full) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // Payload storage needs no reset; validity comes from the pointers
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_tail] <= i_push_entry;
        end
    end

    // Entry i is live when its distance from head is below the count
    always_comb begin : p_valid
        logic [PTR_W-1:0] ofs;
        ofs     = '0;
        o_valid = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            ofs        = PTR_W'(i) - r_head;
            o_valid[i] = ({1'b0, ofs} < r_count);
        end
    end

    assign o_head_entry = r_mem[r_head];
    assign o_head       = r_head;
    assign o_entries    = r_mem;
    assign o_overflow   = r_overflow;

endmodule

// File: rtl/store_buffer_dmem.sv
// Write-buffered data-memory port: stores queue in store_fifo and drain over req/ack;
// loads return combinationally. STORE_FORWARD_EN adds youngest-match store forwarding.
// ADDR_W/DATA_W must match the dmem_pkg entry widths.
module store_buffer_dmem
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned ADDR_W = DMEM_ADDR_W,
    parameter int unsigned DATA_W = DMEM_DATA_W
) (
    input  logic                clk,
    input  logic                rst,
    store_buffer_dmem_if.slave  sb
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [ADDR_W-1:0] w_word;
    sb_entry_t         w_push_entry;
    sb_entry_t         w_head_entry;
    sb_entry_t         w_entries [DEPTH];
    logic [DEPTH-1:0]  w_valid;
    logic [PTR_W-1:0]  w_head;
    logic              w_full;
    logic              w_empty;
    logic              w_overflow;
    logic              w_pop;
    logic              w_fwd_hit;
    logic [DATA_W-1:0] w_fwd_data;
    logic              w_unused_addr;

    drain_state_t      r_state;
    logic              r_ram_req;
    logic [ADDR_W-1:0] r_ram_addr;
    logic [DATA_W-1:0] r_ram_wdata;

    assign w_word        = sb.addr[ADDR_W+1:2];
    assign w_unused_addr = ^{sb.addr[31:ADDR_W+2], sb.addr[1:0]};
    assign w_push_entry  = '{addr: w_word, data: sb.wdata};

    // The entry under request is popped only when the RAM acknowledges it
    assign w_pop = (r_state == REQ) && sb.ram_ack;

    store_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk          (clk),
        .rst          (rst),
        .i_push_req   (sb.wr_en),
        .i_push_entry (w_push_entry),
        .i_pop        (w_pop),
        .o_head_entry (w_head_entry),
        .o_head       (w_head),
        .o_entries    (w_entries),
        .o_valid      (w_valid),
        .o_full       (w_full),
        .o_empty      (w_empty),
        .o_overflow   (w_overflow)
    );

    // Drain FSM: latch head onto the RAM bus, hold it until ack
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= IDLE;
            r_ram_req   <= 1'b0;
            r_ram_addr  <= '0;
            r_ram_wdata <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (!w_empty) begin
                        r_ram_addr  <= w_head_entry.addr;
                        r_ram_wdata <= w_head_entry.data;
                        r_ram_req   <= 1'b1;
                        r_state     <= REQ;
                    end
                end
                REQ: begin
                    if (sb.ram_ack) begin
                        r_ram_req <= 1'b0;
                        r_state   <= IDLE;
                    end
                end
                default: begin
                    r_ram_req <= 1'b0;
                    r_state   <= IDLE;
                end
            endcase
        end
    end

`ifdef STORE_FORWARD_EN
    // Walk oldest to youngest so the last match (nearest tail) wins
    always_comb begin : p_forward
        logic [PTR_W-1:0] idx;
        idx        = w_head;
        w_fwd_hit  = 1'b0;
        w_fwd_data = '0;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            if (w_valid[idx] && (w_entries[idx].addr == w_word)) begin
                w_fwd_hit  = 1'b1;
                w_fwd_data = w_entries[idx].data;
            end
            idx = idx + PTR_W'(1);
        end
    end
`else
    logic             w_unused_fwd;
    logic [DEPTH-1:0] w_unused_entries;

    assign w_fwd_hit    = 1'b0;
    assign w_fwd_data   = '0;
    assign w_unused_fwd = ^{w_valid, w_head};
    for (genvar g = 0; g < DEPTH; g++) begin : g_unused_entries
        assign w_unused_entries[g] = ^w_entries[g];
    end
`endif

    assign sb.rdata     = sb.rd_en ? (w_fwd_hit ? w_fwd_data : sb.ram_rdata) : '0;
    assign sb.ram_raddr = w_word;
    assign sb.full      = w_full;
    assign sb.empty     = w_empty;
    assign sb.overflow  = w_overflow;
    assign sb.ram_req   = r_ram_req;
    assign sb.ram_addr  = r_ram_addr;
    assign sb.ram_wdata = r_ram_wdata;

endmodule

// File: tb/tb_store_buffer_dmem.sv
// Directed bench for store_buffer_dmem; expected values are hand-computed.
// Forwarding expectations follow STORE_FORWARD_EN.
module tb_store_buffer_dmem;

    logic clk = 1'b0;
    logic rst;
    int   n_vec = 0;
    int   n_err = 0;

    store_buffer_dmem_if sb_if ();

    store_buffer_dmem dut (
        .clk (clk),
        .rst (rst),
        .sb  (sb_if)
    );

    always #5 clk = ~clk;

`ifdef STORE_FORWARD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] a, input logic [31:0] d);
        sb_if.wr_en = 1'b1;
        sb_if.addr  = a;
        sb_if.wdata = d;
        tick();
        sb_if.wr_en = 1'b0;
    endtask

    task automatic wait_req(input string tag);
        int n = 0;
        while (!sb_if.ram_req && n < 10) begin
            tick();
            n++;
        end
        chk({tag, "_req"}, 32'(sb_if.ram_req), 32'd1);
    endtask

    task automatic drain_one(input string tag, input logic [31:0] exp_addr, input logic [31:0] exp_data);
        wait_req(tag);
        chk({tag, "_addr"}, 32'(sb_if.ram_addr), exp_addr);
        chk({tag, "_data"}, sb_if.ram_wdata, exp_data);
        sb_if.ram_ack = 1'b1;
        tick();
        sb_if.ram_ack = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        // reset held with a store request present
        rst             = 1'b0;
        sb_if.wr_en     = 1'b1;
        sb_if.rd_en     = 1'b0;
        sb_if.addr      = 32'h10;
        sb_if.wdata     = 32'h1234;
        sb_if.ram_ack   = 1'b0;
        sb_if.ram_rdata = 32'hDEAD;
        repeat (3) tick();
        chk("rst_full",  32'(sb_if.full), 32'd0);
        chk("rst_empty", 32'(sb_if.empty), 32'd1);
        chk("rst_req",   32'(sb_if.ram_req), 32'd0);
        chk("rst_ovf",   32'(sb_if.overflow), 32'd0);
        chk("rst_rdata", sb_if.rdata, 32'd0);
        chk("rst_raddr", 32'(sb_if.ram_addr), 32'd0);
        sb_if.wr_en = 1'b0;
        rst         = 1'b1;
        tick();
        chk("post_rst_req", 32'(sb_if.ram_req), 32'd0);

        // single store: request one cycle after push, held until ack
        push(32'h10, 32'hCAFE0001);
        chk("s1_empty", 32'(sb_if.empty), 32'd0);
        chk("s1_noreq", 32'(sb_if.ram_req), 32'd0);
        tick();
        chk("s1_req",   32'(sb_if.ram_req), 32'd1);
        chk("s1_addr",  32'(sb_if.ram_addr), 32'd4);
        chk("s1_data",  sb_if.ram_wdata, 32'hCAFE0001);
        tick();
        tick();
        chk("s1_hold_req",  32'(sb_if.ram_req), 32'd1);
        chk("s1_hold_addr", 32'(sb_if.ram_addr), 32'd4);
        chk("s1_hold_data", sb_if.ram_wdata, 32'hCAFE0001);
        sb_if.ram_ack = 1'b1;
        tick();
        sb_if.ram_ack = 1'b0;
        chk("s1_done_req",   32'(sb_if.ram_req), 32'd0);
        chk("s1_done_empty", 32'(sb_if.empty), 32'd1);
        // stray ack in IDLE does nothing
        sb_if.ram_ack = 1'b1;
        tick();
        tick();
        sb_if.ram_ack = 1'b0;
        chk("idle_ack_req",   32'(sb_if.ram_req), 32'd0);
        chk("idle_ack_empty", 32'(sb_if.empty), 32'd1);

        // fill to full, drop a fifth store, drain four in order
        for (int k = 0; k < 4; k++) push(32'h100 + 32'(4 * k), 32'hD000_0000 + 32'(k));
        chk("fill_full", 32'(sb_if.full), 32'd1);
        chk("fill_ovf0", 32'(sb_if.overflow), 32'd0);
        push(32'h110, 32'hDEAD0005);
        chk("drop_ovf",  32'(sb_if.overflow), 32'd1);
        chk("drop_full", 32'(sb_if.full), 32'd1);
        for (int k = 0; k < 4; k++) drain_one($sformatf("fill%0d", k), 32'h40 + 32'(k), 32'hD000_0000 + 32'(k));
        chk("fill_empty", 32'(sb_if.empty), 32'd1);
        repeat (4) tick();
        chk("fill_no5th", 32'(sb_if.ram_req), 32'd0);
        chk("ovf_sticky", 32'(sb_if.overflow), 32'd1);

        // forwarding: two stores to 0x20, load returns youngest (or RAM data)
        push(32'h20, 32'h11);
        push(32'h20, 32'h22);
        sb_if.rd_en = 1'b1;
        sb_if.addr  = 32'h20;
        #1;
        chk("fwd_young", sb_if.rdata, FWD ? 32'h22 : 32'hDEAD);
        chk("fwd_raddr", 32'(sb_if.ram_raddr), 32'd8);
        sb_if.addr = 32'h24;
        #1;
        chk("fwd_miss", sb_if.rdata, 32'hDEAD);
        // same-cycle store to the load address is invisible to that load
        sb_if.addr  = 32'h20;
        sb_if.wr_en = 1'b1;
        sb_if.wdata = 32'h33;
        #1;
        chk("fwd_same_cyc", sb_if.rdata, FWD ? 32'h22 : 32'hDEAD);
        tick();
        sb_if.wr_en = 1'b0;
        chk("fwd_newest", sb_if.rdata, FWD ? 32'h33 : 32'hDEAD);
        sb_if.rd_en = 1'b0;
        #1;
        chk("rd_off", sb_if.rdata, 32'd0);
        drain_one("fwd_a", 32'h8, 32'h11);
        drain_one("fwd_b", 32'h8, 32'h22);
        wait_req("fwd_c_pre");
        sb_if.rd_en = 1'b1;
        #1;
        chk("fwd_in_req", sb_if.rdata, FWD ? 32'h33 : 32'hDEAD);
        sb_if.rd_en = 1'b0;
        drain_one("fwd_c", 32'h8, 32'h33);
        chk("fwd_empty", 32'(sb_if.empty), 32'd1);

        // same-cycle push and pop
        rst = 1'b0;
        #2;
        rst = 1'b1;
        chk("rst2_ovf", 32'(sb_if.overflow), 32'd0);
        for (int k = 0; k < 4; k++) push(32'h200 + 32'(4 * k), 32'hE000_0000 + 32'(k));
        chk("pp_full", 32'(sb_if.full), 32'd1);
        wait_req("pp_e0");
        chk("pp_e0_addr", 32'(sb_if.ram_addr), 32'h80);
        sb_if.ram_ack = 1'b1;
        sb_if.wr_en   = 1'b1;
        sb_if.addr    = 32'h210;
        sb_if.wdata   = 32'hE000_0004;
        tick();
        sb_if.ram_ack = 1'b0;
        sb_if.wr_en   = 1'b0;
        chk("pp_full_drop_ovf",  32'(sb_if.overflow), 32'd1);
        chk("pp_full_drop_full", 32'(sb_if.full), 32'd0);
        wait_req("pp_e1");
        chk("pp_e1_addr", 32'(sb_if.ram_addr), 32'h81);
        sb_if.ram_ack = 1'b1;
        sb_if.wr_en   = 1'b1;
        sb_if.addr    = 32'h214;
        sb_if.wdata   = 32'hE000_0005;
        tick();
        sb_if.ram_ack = 1'b0;
        sb_if.wr_en   = 1'b0;
        chk("pp_cnt3_full",  32'(sb_if.full), 32'd0);
        chk("pp_cnt3_empty", 32'(sb_if.empty), 32'd0);
        drain_one("pp_e2", 32'h82, 32'hE000_0002);
        drain_one("pp_e3", 32'h83, 32'hE000_0003);
        drain_one("pp_e5", 32'h85, 32'hE000_0005);
        chk("pp_empty", 32'(sb_if.empty), 32'd1);
        repeat (3) tick();
        chk("pp_no_extra", 32'(sb_if.ram_req), 32'd0);

        // reset in the middle of a handshake
        push(32'h300, 32'hA000_0000);
        push(32'h304, 32'hA000_0001);
        wait_req("mid");
        rst = 1'b0;
        #1;
        chk("mid_req",   32'(sb_if.ram_req), 32'd0);
        chk("mid_empty", 32'(sb_if.empty), 32'd1);
        chk("mid_addr",  32'(sb_if.ram_addr), 32'd0);
        #2;
        rst = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick();
            chk($sformatf("mid_quiet%0d", k), 32'(sb_if.ram_req), 32'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
